mem_port_arbiter: RTL and testbench

Arbitrates the single-ported main memory between the CPU memory path (instruction fetch and data LDR/STR/PSH/POP/JMS/RET accesses issued by the control unit) and an external requester (program loader / debug port). Sits between both requesters and the memory. It runs a small issue/wait/complete state machine per transaction. CPU has fixed priority, with a starvation counter that guarantees the external port progress.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter, CPU priority with EXT starvation guard
// Optional cpu_lock input enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          cpu_lock,
`endif
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          cpu_gnt,
    output logic          ext_gnt,
    output logic          cpu_done,
    output logic          ext_done,
    output logic [DW-1:0] cpu_rdata,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_EXT} own_t;

    state_t        state, state_nxt;
    own_t          own;
    logic          we_r;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lat_cnt;
    logic          arb, ext_win, cpu_win, lat_last;

`ifndef MEM_ARB_LOCK_EN
    logic cpu_lock;
    assign cpu_lock = 1'b0;
`endif

    // Arbitration happens only in IDLE and DONE, so DONE can flow straight into the next ISSUE.
    assign arb      = (state == S_IDLE) || (state == S_DONE);
    assign ext_win  = arb && ext_req && !cpu_lock &&
                      (!cpu_req || (starve_cnt == SW'(STARVE_MAX)));
    assign cpu_win  = arb && cpu_req && !ext_win;
    assign lat_last = (state == S_WAIT) && (lat_cnt == LW'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = (ext_win || cpu_win) ? S_ISSUE : S_IDLE;
            S_ISSUE:        state_nxt = S_WAIT;
            S_WAIT:         if (lat_last) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign mem_en   = (state == S_ISSUE);
    assign mem_we   = (state == S_ISSUE) && we_r;
    assign cpu_gnt  = (state == S_ISSUE) && (own == OWN_CPU);
    assign ext_gnt  = (state == S_ISSUE) && (own == OWN_EXT);
    assign cpu_done = (state == S_DONE) && (own == OWN_CPU);
    assign ext_done = (state == S_DONE) && (own == OWN_EXT);

    // mem_addr/mem_wdata double as the registered copy of the winner's request and hold afterwards.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            own        <= OWN_CPU;
            we_r       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
        end else begin
            if (ext_win) begin
                own       <= OWN_EXT;
                we_r      <= ext_we;
                mem_addr  <= ext_addr;
                mem_wdata <= ext_wdata;
            end else if (cpu_win) begin
                own       <= OWN_CPU;
                we_r      <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end

            if (arb) begin
                if (ext_win || !ext_req)
                    starve_cnt <= '0;
                else if (cpu_win && (starve_cnt != SW'(STARVE_MAX)))
                    starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == S_ISSUE)
                lat_cnt <= '0;
            else if (state == S_WAIT)
                lat_cnt <= lat_cnt + 1'b1;

            if (lat_last && !we_r) begin
                if (own == OWN_EXT) ext_rdata <= mem_rdata;
                else                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MEM_LAT = 2;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
    logic          cpu_gnt, ext_gnt, cpu_done, ext_done;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
    logic          cpu_lock = 1'b0;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef MEM_ARB_LOCK_EN
        .cpu_lock(cpu_lock),
`endif
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .cpu_gnt(cpu_gnt), .ext_gnt(ext_gnt), .cpu_done(cpu_done), .ext_done(ext_done),
        .cpu_rdata(cpu_rdata), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory: samples mem_en on the edge; read data then stays stable through WAIT.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // One isolated transaction from IDLE; returns gnt/done latencies in cycles.
    task automatic xact(input bit ext, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                        output logic g_we, output logic [AW-1:0] g_addr,
                        output logic [DW-1:0] g_wdata, output int g_lat, output int d_lat);
        if (ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        g_lat = 0;
        do begin
            @(negedge clk);
            g_lat++;
        end while (!(ext ? ext_gnt : cpu_gnt) && g_lat < 20);
        g_we = mem_we;
        g_addr = mem_addr;
        g_wdata = mem_wdata;
        cpu_req = 1'b0;
        ext_req = 1'b0;
        d_lat = 0;
        do begin
            @(negedge clk);
            d_lat++;
        end while (!(ext ? ext_done : cpu_done) && d_lat < 20);
        rd = ext ? ext_rdata : cpu_rdata;
    endtask

    initial begin
        logic [DW-1:0] rd, gwd;
        logic          gwe;
        logic [AW-1:0] gaddr;
        int            gl, dl, n, cyc, last, k;
        string         exp_seq;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i) ^ 16'hA5A5;
        mem[5] = 16'h1234;

        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        rst_b = 1'b1;

        // CPU read of 0x005
        xact(1'b0, 1'b0, 10'h005, 16'h0, rd, gwe, gaddr, gwd, gl, dl);
        check("cpu_rd_gnt_lat", 32'(gl), 32'd1);
        check("cpu_rd_we", {31'd0, gwe}, 32'd0);
        check("cpu_rd_addr", 32'(gaddr), 32'h005);
        check("cpu_rd_done_lat", 32'(dl), 32'(MEM_LAT + 1));
        check("cpu_rd_data", 32'(rd), 32'h1234);
        @(negedge clk);
        check("cpu_done_pulse", {31'd0, cpu_done}, 32'd0);
        check("cpu_idle_busy", {31'd0, busy}, 32'd0);

        // EXT read 0x007, write 0x3FF, read 0x3FF
        xact(1'b1, 1'b0, 10'h007, 16'h0, rd, gwe, gaddr, gwd, gl, dl);
        check("ext_rd7_data", 32'(rd), 32'h0000A5A2);
        xact(1'b1, 1'b1, 10'h3FF, 16'hBEEF, rd, gwe, gaddr, gwd, gl, dl);
        check("ext_wr_we", {31'd0, gwe}, 32'd1);
        check("ext_wr_addr", 32'(gaddr), 32'h3FF);
        check("ext_wr_wdata", 32'(gwd), 32'hBEEF);
        check("ext_wr_done_lat", 32'(dl), 32'(MEM_LAT + 1));
        check("ext_wr_rdata_held", 32'(rd), 32'h0000A5A2);
        check("cpu_rdata_untouched", 32'(cpu_rdata), 32'h1234);
        xact(1'b1, 1'b0, 10'h3FF, 16'h0, rd, gwe, gaddr, gwd, gl, dl);
        check("ext_rd_back", 32'(rd), 32'hBEEF);

        // Continuous contention: 4 CPU grants then 1 EXT, repeating
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'h020;
        exp_seq = "CCCCECCCCE";
        n = 0; cyc = 0; last = -1;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cpu_gnt && ext_gnt) check("dual_gnt", 32'd1, 32'd0);
            if (cpu_gnt || ext_gnt) begin
                check($sformatf("grant%0d", n), ext_gnt ? 32'h45 : 32'h43, 32'(exp_seq[n]));
                if (last >= 0) check("grant_spacing", 32'(cyc - last), 32'(MEM_LAT + 2));
                last = cyc;
                n++;
            end
        end
        check("grant_count", 32'(n), 32'd10);
        cpu_req = 1'b0;
        ext_req = 1'b0;
        wait_idle();
        check("cpu_contend_rdata", 32'(cpu_rdata), 32'h0000A5B5);
        check("ext_contend_rdata", 32'(ext_rdata), 32'h0000A585);

        // Simultaneous first requests, CPU drops after its grant
        cpu_req = 1'b1; ext_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(cpu_gnt || ext_gnt) && k < 20);
        check("simul_first_cpu", {30'd0, cpu_gnt, ext_gnt}, 32'd2);
        cpu_req = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ext_gnt && k < 20);
        check("simul_ext_slot", 32'(k), 32'(MEM_LAT + 2));
        ext_req = 1'b0;
        wait_idle();

        // Reset during WAIT of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cpu_gnt && k < 20);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_done || busy) k++;
        end
        check("midrst_no_done", 32'(k), 32'd0);
        xact(1'b0, 1'b0, 10'h005, 16'h0, rd, gwe, gaddr, gwd, gl, dl);
        check("postrst_gnt_lat", 32'(gl), 32'd1);
        check("postrst_data", 32'(rd), 32'h1234);

`ifdef MEM_ARB_LOCK_EN
        @(negedge clk);
        cpu_lock = 1'b1;
        cpu_req = 1'b1; ext_req = 1'b1;
        n = 0; k = 0; cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ext_gnt) k++;
            if (cpu_gnt) n++;
        end
        check("lock_cpu_grants", 32'(n), 32'd10);
        check("lock_no_ext", 32'(k), 32'd0);
        cpu_lock = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(cpu_gnt || ext_gnt) && cyc < 20);
        check("unlock_ext_next", {30'd0, cpu_gnt, ext_gnt}, 32'd1);
        check("unlock_ext_slot", 32'(cyc), 32'(MEM_LAT + 2));
        cpu_req = 1'b0;
        ext_req = 1'b0;
        wait_idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
